sensor_readout_controller: RTL and testbench
============================================

Name: sensor_readout_controller

Overview:
Sequences readout of the pixel array after the row-scan state machine selects each row. On every NEW_ROW pulse it captures the selected row's parallel pixel bus into a two-bank ping-pong row buffer. It then serializes the buffered pixels one column per beat onto a valid/ready stream with row, column and frame markers. It also flags rows lost to consumer backpressure.

Parameters:
WIDTH, 2, pixel columns per row (PIXEL_ARRAY_WIDTH)
HEIGHT, 2, rows per frame (PIXEL_ARRAY_HEIGHT)
PIXEL_BITS, 8, bits per pixel value

Ports:
CLK  in  1  clock; all state updates on posedge
RESET  in  1  asynchronous, active-low reset
NEW_ROW  in  1  one-cycle pulse; PIXEL_DATA valid in the same cycle
FRAME_FINISHED  in  1  one-cycle pulse; frame scan complete
PIXEL_DATA  in  WIDTH*PIXEL_BITS  column c = bits [c*PIXEL_BITS +: PIXEL_BITS]
OUT_DATA  out  PIXEL_BITS  current pixel value
OUT_VALID  out  1  beat available
OUT_READY  in  1  consumer accepts the beat when OUT_VALID & OUT_READY
OUT_COL  out  $clog2(WIDTH) (min 1)  column index of beat
OUT_ROW  out  $clog2(HEIGHT) (min 1)  row index of beat
OUT_FIRST  out  1  beat is row 0, column 0
OUT_LAST  out  1  beat is row HEIGHT-1, column WIDTH-1
OVERFLOW  out  1  sticky; at least one row dropped
OVERFLOW_CLEAR  in  1  clears OVERFLOW

Behaviour:
- Reset (RESET=0, async):
  - All outputs are 0.
  - Both banks are empty; write-bank pointer and read-bank pointer are 0.
  - Row counter is 0; column counter is 0.
- Each bank holds WIDTH pixels, a row tag and a full flag.
- Capture:
  - Condition: NEW_ROW=1 at a posedge and the write bank is empty, or is being released in that same cycle.
  - Action: store PIXEL_DATA and the current row counter in the write bank, set its full flag, toggle the write pointer, then increment the row counter.
  - Row counter wraps from HEIGHT-1 to 0.
- Drop:
  - Condition: NEW_ROW=1 while the write bank is full and not being released.
  - Action: PIXEL_DATA is discarded and OVERFLOW is set to 1.
  - The row counter still increments, so row tags stay aligned with the physical scan.
- FRAME_FINISHED=1 forces the row counter to 0 on the next edge.
  - If NEW_ROW occurs in the same cycle, the capture uses the pre-reset row value and the counter becomes 0, not +1.
- Stream FSM, two states:
  - IDLE: OUT_VALID=0. Moves to SEND when the read bank is full; OUT_VALID is asserted from the following cycle.
  - SEND: OUT_VALID=1. OUT_DATA is the column-counter pixel of the read bank; OUT_ROW is the bank's row tag.
  - OUT_FIRST = (tag==0 && col==0). OUT_LAST = (tag==HEIGHT-1 && col==WIDTH-1).
  - All stream outputs are registered and stay stable while OUT_VALID & ~OUT_READY.
  - On handshake with col<WIDTH-1: increment col.
  - On handshake with col==WIDTH-1: col←0, clear the bank's full flag (release), toggle the read pointer.
  - After release: stay in SEND if the other bank is full (back-to-back rows, no bubble); otherwise return to IDLE.
- Latency: a capture at edge t with the stream idle gives OUT_VALID=1 after edge t+1, at one beat per cycle while OUT_READY=1.
- Capacity: the buffer holds 2 full rows; a third NEW_ROW before any release is dropped.
- Capture into the bank being released in the same cycle is legal. New data is visible from the next cycle; the old last beat is unaffected.
- OVERFLOW:
  - Set by a drop. Cleared by OVERFLOW_CLEAR=1.
  - A drop and OVERFLOW_CLEAR in the same cycle leave OVERFLOW=1 (set wins).
- Mid-operation reset discards buffered rows and partial beats, with no handshake completion.
- OUT_DATA is 0 whenever OUT_VALID=0.

Test Plan:
1. Single row, ready high. Stimulus: reset; NEW_ROW with PIXEL_DATA=16'hB2A1. Required: beats (A1,row0,col0,FIRST=1), then (B2,row0,col1,LAST=0); OUT_VALID rises one cycle after capture.
2. Full frame, ready high. Stimulus: NEW_ROW 16'h2211, then NEW_ROW 16'h4433, 5 cycles apart. Required: stream 11,22,33,44; OUT_LAST only on 44 (row1,col1); the next NEW_ROW is tagged row0.
3. Backpressure. Stimulus: OUT_READY held 0 for 4 cycles during the first beat. Required: OUT_DATA=11, OUT_COL=0, OUT_VALID=1 stay stable; resumes with no loss after ready.
4. Overflow. Stimulus: OUT_READY=0; three NEW_ROWs (11/22, 33/44, 55/66). Required: OVERFLOW=1 after the third; stream yields only 11,22,33,44. Then pulse OVERFLOW_CLEAR; required: OVERFLOW=0.
5. Same-cycle release and capture. Stimulus: both banks full; NEW_ROW coincides with the handshake of the last beat of bank 0. Required: the new row is captured, OVERFLOW stays 0, and it streams after bank 1.
6. Resync and reset. Stimulus: FRAME_FINISHED together with a NEW_ROW tagged row0 (HEIGHT=2), then another NEW_ROW. Required: the second NEW_ROW is tagged row0. Then assert RESET low mid-beat; required: all outputs 0 immediately, banks empty.

Source files
------------

// File: rtl/sensor_readout_controller.sv
// Sensor readout controller: captures each scanned pixel row into a
// two-bank ping-pong buffer and streams it out one column per beat with
// row/column/frame markers. A row that arrives while both banks are still
// occupied is dropped and flagged on the sticky OVERFLOW output.

// One row-buffer bank: pixel row, row tag and occupancy flag.
module sensor_row_bank #(
  parameter int WIDTH      = 2,
  parameter int PIXEL_BITS = 8,
  parameter int ROW_W      = 1
) (
  input  logic                              CLK,
  input  logic                              RESET,
  input  logic                              load,
  input  logic                              rel_bank,
  input  logic [WIDTH-1:0][PIXEL_BITS-1:0]  pix_in,
  input  logic [ROW_W-1:0]                  tag_in,
  output logic [WIDTH-1:0][PIXEL_BITS-1:0]  pix,
  output logic [ROW_W-1:0]                  tag,
  output logic                              full
);
  // A load in the same cycle as a release wins, so the bank stays full with new data.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      pix  <= '0;
      tag  <= '0;
      full <= 1'b0;
    end else if (load) begin
      pix  <= pix_in;
      tag  <= tag_in;
      full <= 1'b1;
    end else if (rel_bank) begin
      full <= 1'b0;
    end
  end
endmodule

module sensor_readout_controller #(
  parameter int WIDTH      = 2,
  parameter int HEIGHT     = 2,
  parameter int PIXEL_BITS = 8,
  localparam int COL_W     = (WIDTH  > 1) ? $clog2(WIDTH)  : 1,
  localparam int ROW_W     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        NEW_ROW,
  input  logic                        FRAME_FINISHED,
  input  logic [WIDTH*PIXEL_BITS-1:0] PIXEL_DATA,
  output logic [PIXEL_BITS-1:0]       OUT_DATA,
  output logic                        OUT_VALID,
  input  logic                        OUT_READY,
  output logic [COL_W-1:0]            OUT_COL,
  output logic [ROW_W-1:0]            OUT_ROW,
  output logic                        OUT_FIRST,
  output logic                        OUT_LAST,
  output logic                        OVERFLOW,
  input  logic                        OVERFLOW_CLEAR
);
  localparam logic [0:0]       IDLE     = 1'b0;
  localparam logic [0:0]       SEND     = 1'b1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(HEIGHT - 1);

  logic [WIDTH-1:0][PIXEL_BITS-1:0]       pix_in;
  logic [1:0][WIDTH-1:0][PIXEL_BITS-1:0]  bank_pix;
  logic [1:0][ROW_W-1:0]                  bank_tag;
  logic [1:0]                             bank_full;

  logic [0:0]       state, state_n;
  logic             wr_ptr, rd_ptr, rd_n;
  logic [COL_W-1:0] col, col_n;
  logic [ROW_W-1:0] row_cnt;
  logic             rel, capture, drop, send_n;

  assign pix_in = PIXEL_DATA;

  // Last beat of the read bank is handed off this cycle.
  assign rel     = (state == SEND) && OUT_READY && (col == LAST_COL);
  // Write bank is free, or is the bank being released right now.
  assign capture = NEW_ROW && (!bank_full[wr_ptr] || (rel && (rd_ptr == wr_ptr)));
  assign drop    = NEW_ROW && !capture;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    sensor_row_bank #(
      .WIDTH(WIDTH), .PIXEL_BITS(PIXEL_BITS), .ROW_W(ROW_W)
    ) u_bank (
      .CLK      (CLK),
      .RESET    (RESET),
      .load     (capture && (wr_ptr == 1'(b))),
      .rel_bank (rel && (rd_ptr == 1'(b))),
      .pix_in   (pix_in),
      .tag_in   (row_cnt),
      .pix      (bank_pix[b]),
      .tag      (bank_tag[b]),
      .full     (bank_full[b])
    );
  end

  // Write pointer advances per capture; row counter tracks every scanned row, drops included.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wr_ptr  <= 1'b0;
      row_cnt <= '0;
    end else begin
      if (capture) wr_ptr <= ~wr_ptr;
      if (FRAME_FINISHED)
        row_cnt <= '0;
      else if (NEW_ROW)
        row_cnt <= (row_cnt == LAST_ROW) ? '0 : row_cnt + 1'b1;
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)              OVERFLOW <= 1'b0;
    else if (drop)           OVERFLOW <= 1'b1;
    else if (OVERFLOW_CLEAR) OVERFLOW <= 1'b0;
  end

  // Next stream position: which bank/column is presented after this edge.
  always_comb begin
    state_n = state;
    rd_n    = rd_ptr;
    col_n   = col;
    case (state)
      IDLE: begin
        if (bank_full[rd_ptr]) begin
          state_n = SEND;
          col_n   = '0;
        end
      end
      default: begin
        if (OUT_READY) begin
          if (col == LAST_COL) begin
            rd_n  = ~rd_ptr;
            col_n = '0;
            if (!bank_full[~rd_ptr]) state_n = IDLE;
          end else begin
            col_n = col + 1'b1;
          end
        end
      end
    endcase
  end

  assign send_n = (state_n == SEND);

  // Registered stream outputs, reloaded from the buffer each cycle (stable under stall).
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state     <= IDLE;
      rd_ptr    <= 1'b0;
      col       <= '0;
      OUT_VALID <= 1'b0;
      OUT_DATA  <= '0;
      OUT_COL   <= '0;
      OUT_ROW   <= '0;
      OUT_FIRST <= 1'b0;
      OUT_LAST  <= 1'b0;
    end else begin
      state     <= state_n;
      rd_ptr    <= rd_n;
      col       <= col_n;
      OUT_VALID <= send_n;
      OUT_DATA  <= send_n ? bank_pix[rd_n][col_n] : '0;
      OUT_COL   <= send_n ? col_n : '0;
      OUT_ROW   <= send_n ? bank_tag[rd_n] : '0;
      OUT_FIRST <= send_n && (bank_tag[rd_n] == '0) && (col_n == '0);
      OUT_LAST  <= send_n && (bank_tag[rd_n] == LAST_ROW) && (col_n == LAST_COL);
    end
  end
endmodule

// File: tb/tb_sensor_readout_controller.sv
// Directed bench for sensor_readout_controller with a beat scoreboard:
// stimulus pushes expected beats, a negedge monitor pops on each handshake.
module tb_sensor_readout_controller;
  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        NEW_ROW = 1'b0;
  logic        FRAME_FINISHED = 1'b0;
  logic [15:0] PIXEL_DATA = '0;
  logic [7:0]  OUT_DATA;
  logic        OUT_VALID;
  logic        OUT_READY = 1'b1;
  logic        OUT_COL;
  logic        OUT_ROW;
  logic        OUT_FIRST;
  logic        OUT_LAST;
  logic        OVERFLOW;
  logic        OVERFLOW_CLEAR = 1'b0;

  typedef struct packed {
    logic [7:0] d;
    logic       c;
    logic       r;
    logic       f;
    logic       l;
  } beat_t;

  beat_t sb[$];
  int n_vec = 0;
  int n_err = 0;

  sensor_readout_controller #(.WIDTH(2), .HEIGHT(2), .PIXEL_BITS(8)) dut (
    .CLK(CLK), .RESET(RESET), .NEW_ROW(NEW_ROW), .FRAME_FINISHED(FRAME_FINISHED),
    .PIXEL_DATA(PIXEL_DATA), .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY), .OUT_COL(OUT_COL), .OUT_ROW(OUT_ROW),
    .OUT_FIRST(OUT_FIRST), .OUT_LAST(OUT_LAST), .OVERFLOW(OVERFLOW),
    .OVERFLOW_CLEAR(OVERFLOW_CLEAR)
  );

  always #5 CLK = ~CLK;

  // Monitor: every accepted beat is compared against the scoreboard head.
  always @(negedge CLK) begin
    if (RESET && OUT_VALID && OUT_READY) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL beat_unexpected got d=%h c=%0d r=%0d f=%0d l=%0d",
                 OUT_DATA, OUT_COL, OUT_ROW, OUT_FIRST, OUT_LAST);
      end else begin
        beat_t e;
        e = sb.pop_front();
        if ({OUT_DATA, OUT_COL, OUT_ROW, OUT_FIRST, OUT_LAST} !== e) begin
          n_err++;
          $display("FAIL beat got d=%h c=%0d r=%0d f=%0d l=%0d exp d=%h c=%0d r=%0d f=%0d l=%0d",
                   OUT_DATA, OUT_COL, OUT_ROW, OUT_FIRST, OUT_LAST, e.d, e.c, e.r, e.f, e.l);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic c, input logic r,
                      input logic f, input logic l);
    sb.push_back({d, c, r, f, l});
  endtask

  task automatic new_row(input logic [15:0] data);
    NEW_ROW = 1'b1;
    PIXEL_DATA = data;
    cyc(1);
    NEW_ROW = 1'b0;
  endtask

  task automatic do_reset();
    chk("sb_empty", sb.size(), 0);
    sb.delete();
    RESET = 1'b0;
    OUT_READY = 1'b1;
    cyc(2);
    RESET = 1'b1;
    cyc(1);
  endtask

  initial begin
    // Reset state
    cyc(2);
    chk("rst_valid", OUT_VALID, 0);
    chk("rst_data", OUT_DATA, 0);
    chk("rst_flags", {OUT_COL, OUT_ROW, OUT_FIRST, OUT_LAST, OVERFLOW}, 0);
    RESET = 1'b1;
    cyc(1);

    // 1: single row, latency
    push(8'hA1, 0, 0, 1, 0);
    push(8'hB2, 1, 0, 0, 0);
    new_row(16'hB2A1);
    chk("t1_valid_after_capture", OUT_VALID, 0);
    cyc(1);
    chk("t1_valid_next", OUT_VALID, 1);
    chk("t1_data_first", OUT_DATA, 8'hA1);
    cyc(4);
    chk("t1_idle", OUT_VALID, 0);

    // 2: full frame, wrap of the row tag
    do_reset();
    push(8'h11, 0, 0, 1, 0);
    push(8'h22, 1, 0, 0, 0);
    push(8'h33, 0, 1, 0, 0);
    push(8'h44, 1, 1, 0, 1);
    push(8'h55, 0, 0, 1, 0);
    push(8'h66, 1, 0, 0, 0);
    new_row(16'h2211);
    cyc(4);
    new_row(16'h4433);
    cyc(4);
    new_row(16'h6655);
    cyc(5);

    // 3: backpressure on the first beat
    do_reset();
    push(8'h11, 0, 0, 1, 0);
    push(8'h22, 1, 0, 0, 0);
    OUT_READY = 1'b0;
    new_row(16'h2211);
    cyc(1);
    for (int i = 0; i < 4; i++) begin
      chk("t3_stall_valid", OUT_VALID, 1);
      chk("t3_stall_data", OUT_DATA, 8'h11);
      chk("t3_stall_col", OUT_COL, 0);
      cyc(1);
    end
    OUT_READY = 1'b1;
    cyc(4);
    chk("t3_drained", OUT_VALID, 0);

    // 4: overflow, clear, and drop-beats-clear
    do_reset();
    OUT_READY = 1'b0;
    push(8'h11, 0, 0, 1, 0);
    push(8'h22, 1, 0, 0, 0);
    push(8'h33, 0, 1, 0, 0);
    push(8'h44, 1, 1, 0, 1);
    new_row(16'h2211);
    new_row(16'h4433);
    chk("t4_ovf_two_rows", OVERFLOW, 0);
    new_row(16'h6655);
    chk("t4_ovf_set", OVERFLOW, 1);
    OUT_READY = 1'b1;
    cyc(8);
    chk("t4_ovf_sticky", OVERFLOW, 1);
    OVERFLOW_CLEAR = 1'b1;
    cyc(1);
    OVERFLOW_CLEAR = 1'b0;
    chk("t4_ovf_cleared", OVERFLOW, 0);
    // row counter is at 1 after three NEW_ROWs
    OUT_READY = 1'b0;
    push(8'h77, 0, 1, 0, 0);
    push(8'h88, 1, 1, 0, 1);
    push(8'h99, 0, 0, 1, 0);
    push(8'hAA, 1, 0, 0, 0);
    new_row(16'h8877);
    new_row(16'hAA99);
    OVERFLOW_CLEAR = 1'b1;
    new_row(16'hCCBB);
    OVERFLOW_CLEAR = 1'b0;
    chk("t4_set_wins", OVERFLOW, 1);
    OUT_READY = 1'b1;
    cyc(8);

    // 5: release and capture on the same edge
    do_reset();
    OUT_READY = 1'b0;
    push(8'h11, 0, 0, 1, 0);
    push(8'h22, 1, 0, 0, 0);
    push(8'h33, 0, 1, 0, 0);
    push(8'h44, 1, 1, 0, 1);
    push(8'h55, 0, 0, 1, 0);
    push(8'h66, 1, 0, 0, 0);
    new_row(16'h2211);
    new_row(16'h4433);
    chk("t5_first_beat", OUT_DATA, 8'h11);
    OUT_READY = 1'b1;
    cyc(1);
    chk("t5_last_beat_b0", OUT_DATA, 8'h22);
    new_row(16'h6655);
    chk("t5_ovf_clear", OVERFLOW, 0);
    chk("t5_bank1_next", OUT_DATA, 8'h33);
    cyc(6);

    // 6: frame resync, then reset mid-beat
    do_reset();
    push(8'h11, 0, 0, 1, 0);
    push(8'h22, 1, 0, 0, 0);
    push(8'h33, 0, 0, 1, 0);
    push(8'h44, 1, 0, 0, 0);
    FRAME_FINISHED = 1'b1;
    new_row(16'h2211);
    FRAME_FINISHED = 1'b0;
    cyc(4);
    new_row(16'h4433);
    cyc(5);
    chk("t6_sb_drained", sb.size(), 0);
    OUT_READY = 1'b0;
    new_row(16'h6655);
    cyc(1);
    chk("t6_mid_valid", OUT_VALID, 1);
    #2;
    RESET = 1'b0;
    #1;
    chk("t6_async_valid", OUT_VALID, 0);
    chk("t6_async_data", OUT_DATA, 0);
    chk("t6_async_flags", {OUT_COL, OUT_ROW, OUT_FIRST, OUT_LAST, OVERFLOW}, 0);
    cyc(1);
    RESET = 1'b1;
    OUT_READY = 1'b1;
    cyc(4);
    chk("t6_banks_empty", OUT_VALID, 0);
    chk("final_sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
